// File: rtl/debounce_pkg.sv
// debounce_pkg: shared defaults and counter-width helper for the button debouncer
package debounce_pkg;
    localparam int DEFAULT_STABLE_CYCLES = 65536;
    localparam int DEFAULT_REPEAT_DELAY  = 50000000;
    localparam int DEFAULT_REPEAT_PERIOD = 10000000;

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/button_debounce_multi_if.sv
// button_debounce_multi_if: raw button inputs and debounced outputs for all channels
interface button_debounce_multi_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0] btn_raw;
    logic [NUM_CH-1:0] btn_level;
    logic [NUM_CH-1:0] btn_press;
    logic [NUM_CH-1:0] btn_release;
    logic [NUM_CH-1:0] btn_repeat;

    modport master (output btn_raw, input btn_level, btn_press, btn_release, btn_repeat);
    modport slave  (input btn_raw, output btn_level, btn_press, btn_release, btn_repeat);
endinterface

// File: rtl/debounce_channel.sv
// debounce_channel: one button synchroniser, symmetric stability filter, strobes; DEBOUNCE_AUTOREPEAT_EN adds auto-repeat
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int SYNC_STAGES   = 2,
    parameter int REPEAT_DELAY  = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEFAULT_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw_i,
    output logic btn_level_o,
    output logic btn_press_o,
    output logic btn_release_o,
    output logic btn_repeat_o
);
    localparam int CW = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    if (STABLE_CYCLES < 2 || SYNC_STAGES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
        $error("debounce_channel: illegal parameter value");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic level_q, level_d;
    logic press_q, release_q;
    logic s, accept;

    assign s      = sync_q[SYNC_STAGES-1];
    assign accept = (s != level_q) && (cnt_q == CNT_MAX);

    // filter: count consecutive cycles of disagreement, accept the new level at the limit
    always_comb begin
        cnt_d   = (s == level_q || accept) ? '0 : cnt_q + CW'(1);
        level_d = accept ? s : level_q;
    end

    // synchroniser, filter state and registered strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], btn_raw_i};
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= accept & s;
            release_q <= accept & ~s;
        end
    end

    assign btn_level_o   = level_q;
    assign btn_press_o   = press_q;
    assign btn_release_o = release_q;

`ifdef DEBOUNCE_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW = cnt_width(RMAX);
    localparam logic [RW-1:0] DELAY_MAX  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_MAX = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rcnt_q, rcnt_d;
    logic phase_q, phase_d;
    logic repeat_q, repeat_d;
    logic held, rfire;

    // repeat timer: first interval is the delay, later ones the period; a release accept clears it
    always_comb begin
        held     = level_q && !accept;
        rfire    = held && (rcnt_q == (phase_q ? PERIOD_MAX : DELAY_MAX));
        repeat_d = (accept & s) | rfire;
        rcnt_d   = (held && !rfire) ? rcnt_q + RW'(1) : '0;
        phase_d  = held && (phase_q || rfire);
    end

    // repeat timer state and registered repeat strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt_q   <= '0;
            phase_q  <= 1'b0;
            repeat_q <= 1'b0;
        end else begin
            rcnt_q   <= rcnt_d;
            phase_q  <= phase_d;
            repeat_q <= repeat_d;
        end
    end

    assign btn_repeat_o = repeat_q;
`else
    assign btn_repeat_o = 1'b0;
`endif
endmodule

// File: rtl/button_debounce_multi.sv
// button_debounce_multi: NUM_CH independent debounced buttons; DEBOUNCE_AUTOREPEAT_EN enables auto-repeat strobes
module button_debounce_multi
    import debounce_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int SYNC_STAGES   = 2,
    parameter int REPEAT_DELAY  = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEFAULT_REPEAT_PERIOD
) (
    input logic clk,
    input logic rst_n,
    button_debounce_multi_if.slave bus
);
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES(STABLE_CYCLES),
            .SYNC_STAGES  (SYNC_STAGES),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .btn_raw_i    (bus.btn_raw[i]),
            .btn_level_o  (bus.btn_level[i]),
            .btn_press_o  (bus.btn_press[i]),
            .btn_release_o(bus.btn_release[i]),
            .btn_repeat_o (bus.btn_repeat[i])
        );
    end
endmodule

// File: tb/tb_button_debounce_multi.sv
// tb_button_debounce_multi: directed bench for the 4-channel debouncer (STABLE=8, SYNC=2, DELAY=20, PERIOD=5)
module tb_button_debounce_multi;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;

    button_debounce_multi_if #(.NUM_CH(4)) bus ();

    button_debounce_multi #(
        .NUM_CH       (4),
        .STABLE_CYCLES(8),
        .SYNC_STAGES  (2),
        .REPEAT_DELAY (20),
        .REPEAT_PERIOD(5)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // free-running clock, period 10
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] el, ep, er;
        bus.btn_raw = 4'hF;
        rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if ({bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_repeat} !== 16'h0) begin
                bad++;
                $display("FAIL reset_hold c=%0d got=%h exp=0000", c,
                         {bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_repeat});
            end
        end
        rst_n = 1'b1;
        for (int n = 1; n <= 11; n++) begin
            tick();
            el = (n >= 10) ? 4'hF : 4'h0;
            ep = (n == 10) ? 4'hF : 4'h0;
`ifdef DEBOUNCE_AUTOREPEAT_EN
            er = ep;
`else
            er = 4'h0;
`endif
            total++;
            if ({bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_repeat} !== {el, ep, 4'h0, er}) begin
                bad++;
                $display("FAIL reset_release n=%0d got=%h exp=%h", n,
                         {bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_repeat}, {el, ep, 4'h0, er});
            end
        end
    endtask

    task automatic test_release_multi();
        bus.btn_raw = 4'b0010;
        for (int n = 1; n <= 11; n++) begin
            tick();
            if (n == 10) begin
                total++;
                if ({bus.btn_level, bus.btn_press, bus.btn_release} !== {4'b0010, 4'b0000, 4'b1101}) begin
                    bad++;
                    $display("FAIL release_multi got=%h exp=%h",
                             {bus.btn_level, bus.btn_press, bus.btn_release}, {4'b0010, 4'b0000, 4'b1101});
                end
            end
        end
    endtask

    task automatic test_glitch();
        logic seen;
        logic [2:0] e;
        seen = 1'b0;
        bus.btn_raw[0] = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            tick();
            if (n == 7) bus.btn_raw[0] = 1'b0;
            seen = seen | bus.btn_level[0] | bus.btn_press[0];
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL glitch_7 got=%b exp=0", seen);
        end
        bus.btn_raw[0] = 1'b1;
        for (int n = 1; n <= 19; n++) begin
            tick();
            if (n == 8) bus.btn_raw[0] = 1'b0;
            e = {(n >= 10 && n < 18), (n == 10), (n == 18)};
            total++;
            if ({bus.btn_level[0], bus.btn_press[0], bus.btn_release[0]} !== e) begin
                bad++;
                $display("FAIL glitch_8 n=%0d got=%b exp=%b", n,
                         {bus.btn_level[0], bus.btn_press[0], bus.btn_release[0]}, e);
            end
        end
    endtask

    task automatic test_release();
        logic [2:0] e;
        bus.btn_raw[1] = 1'b0;
        for (int n = 1; n <= 11; n++) begin
            tick();
            e = {(n < 10), 1'b0, (n == 10)};
            total++;
            if ({bus.btn_level[1], bus.btn_press[1], bus.btn_release[1]} !== e) begin
                bad++;
                $display("FAIL release_ch1 n=%0d got=%b exp=%b", n,
                         {bus.btn_level[1], bus.btn_press[1], bus.btn_release[1]}, e);
            end
        end
    endtask

    task automatic test_multi();
        logic [3:0] el, ep;
        bus.btn_raw[3:2] = 2'b11;
        for (int t = 0; t < 12; t++) begin
            if (t % 3 == 0) bus.btn_raw[0] = ~bus.btn_raw[0];
            tick();
            el = (t + 1 >= 10) ? 4'b1100 : 4'b0000;
            ep = (t + 1 == 10) ? 4'b1100 : 4'b0000;
            total++;
            if ({bus.btn_level, bus.btn_press} !== {el, ep}) begin
                bad++;
                $display("FAIL multi n=%0d got=%h exp=%h", t + 1, {bus.btn_level, bus.btn_press}, {el, ep});
            end
        end
        bus.btn_raw[0] = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_reset_mid();
        logic [3:0] el, ep;
        bus.btn_raw[1] = 1'b1;
        repeat (7) tick();
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_repeat} !== 16'h0) begin
            bad++;
            $display("FAIL reset_async got=%h exp=0000",
                     {bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_repeat});
        end
        repeat (2) tick();
        rst_n = 1'b1;
        for (int n = 1; n <= 11; n++) begin
            tick();
            el = (n >= 10) ? 4'b1110 : 4'b0000;
            ep = (n == 10) ? 4'b1110 : 4'b0000;
            total++;
            if ({bus.btn_level, bus.btn_press, bus.btn_release} !== {el, ep, 4'h0}) begin
                bad++;
                $display("FAIL reset_mid n=%0d got=%h exp=%h", n,
                         {bus.btn_level, bus.btn_press, bus.btn_release}, {el, ep, 4'h0});
            end
        end
    endtask

    task automatic test_autorepeat();
        logic [3:0] e;
        logic er;
        bus.btn_raw[0] = 1'b1;
        for (int n = 1; n <= 70; n++) begin
            tick();
            if (n == 40) bus.btn_raw[0] = 1'b0;
`ifdef DEBOUNCE_AUTOREPEAT_EN
            er = (n == 10) || (n == 30) || (n == 35) || (n == 40) || (n == 45);
`else
            er = 1'b0;
`endif
            e = {er, (n >= 10 && n < 50), (n == 10), (n == 50)};
            total++;
            if ({bus.btn_repeat[0], bus.btn_level[0], bus.btn_press[0], bus.btn_release[0]} !== e) begin
                bad++;
                $display("FAIL autorepeat n=%0d got=%b exp=%b", n,
                         {bus.btn_repeat[0], bus.btn_level[0], bus.btn_press[0], bus.btn_release[0]}, e);
            end
        end
    endtask

    // run all scenarios in order, then report
    initial begin
        bus.btn_raw = 4'h0;
        test_reset();
        test_release_multi();
        test_glitch();
        test_release();
        test_multi();
        test_reset_mid();
        test_autorepeat();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
